// File: rtl/tbus_read_sequencer_if.sv
// Bundle of request/acknowledge, TINV enable and receive-data signals
// between the read sequencer and the bus sources / driver banks.
// Handshake: a source holds req[i] high until it sees ack[i] for one cycle;
// rvalid strobes for one cycle with rdata/src valid in that same cycle.
// dbg_state / dbg_ptr expose the sequencer's FSM state and round-robin pointer.
interface tbus_read_sequencer_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req;
  logic [N-1:0]  ack;
  logic [N-1:0]  en;
  logic [N-1:0]  nen;
  logic [W-1:0]  bus_in;
  logic [W-1:0]  rdata;
  logic          rvalid;
  logic [SW-1:0] src;
  logic          busy;
  logic [1:0]    dbg_state;
  logic [SW-1:0] dbg_ptr;

  // Sequencer side
  modport master (
    input  req, bus_in,
    output ack, en, nen, rdata, rvalid, src, busy, dbg_state, dbg_ptr
  );

  // Source / driver-bank side
  modport slave (
    output req, bus_in,
    input  ack, en, nen, rdata, rvalid, src, busy, dbg_state, dbg_ptr
  );
endinterface

// File: rtl/tbus_read_sequencer.sv
// Receive-end sequencer for a shared TINV tri-state bus: round-robin
// arbitration, break-before-make EN/nEN generation, and capture of the
// (inverted) bus word with a valid strobe and per-source acknowledge.
module tbus_read_sequencer #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int DEAD  = 1,
  parameter int DRIVE = 2
) (
  input logic clk,
  input logic rst,
  tbus_read_sequencer_if.master bus
);
  localparam int SW   = (N > 1) ? $clog2(N) : 1;
  localparam int CMAX = (DEAD > DRIVE) ? DEAD : DRIVE;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TURN  = 2'd1,
    ST_DRIVE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] grant_q, grant_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  rdata_q, rdata_d;
  logic [SW-1:0] src_q, src_d;
  logic          rvalid_q, rvalid_d;
  logic [N-1:0]  ack_q, ack_d;
  logic          busy_q, busy_d;

  logic          pick_found;
  logic [SW-1:0] pick;

  // Round-robin search: first requesting source at or after ptr (mod N).
  // Scanning offsets high-to-low lets the smallest offset win last.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req[(int'(ptr_q) + i) % N]) begin
        pick_found = 1'b1;
        pick       = SW'((int'(ptr_q) + i) % N);
      end
    end
  end

  // Next-state and registered-output logic for the transfer FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    rdata_d  = rdata_q;
    src_d    = src_q;
    rvalid_d = 1'b0;
    ack_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = pick;
          cnt_d   = CW'(DEAD);
          state_d = ST_TURN;
        end
      end
      ST_TURN: begin
        if (cnt_q == CW'(1)) begin
          cnt_d   = CW'(DRIVE);
          state_d = ST_DRIVE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DRIVE: begin
        if (cnt_q == CW'(1)) begin
          // TINV drivers invert, so the true word is the complement.
          rdata_d  = ~bus.bus_in;
          src_d    = grant_q;
          rvalid_d = 1'b1;
          ack_d    = N'(1) << grant_q;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: begin
        ptr_d   = (int'(grant_q) == N - 1) ? '0 : grant_q + SW'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops the FSM to IDLE at once,
  // which turns every driver off without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      grant_q  <= '0;
      ptr_q    <= '0;
      rdata_q  <= '0;
      src_q    <= '0;
      rvalid_q <= 1'b0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      rdata_q  <= rdata_d;
      src_q    <= src_d;
      rvalid_q <= rvalid_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
    end
  end

  // EN is decoded from registered state and grant only; nEN is its exact
  // complement so the pair can never both be asserted.
  always_comb begin
    bus.en = '0;
    if (state_q == ST_DRIVE) bus.en = N'(1) << grant_q;
  end

  assign bus.nen       = ~bus.en;
  assign bus.ack       = ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.src       = src_q;
  assign bus.busy      = busy_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_ptr   = ptr_q;
endmodule

// File: doc/tbus_read_sequencer.md
Name: tbus_read_sequencer

Overview:
- Receiving end of the shared tri-state data bus built from TINV driver cells.
- Arbitrates between N bus sources and generates each source's complementary EN/nEN pair with break-before-make dead time.
- Samples the bus while one source drives it, removes the TINV inversion, and returns the word with a valid strobe and a per-source acknowledge.
- Sits between the source request logic and the TINV driver banks on each datapath bus.

Parameters:
N, 4, number of bus sources (2..8)
W, 8, bus width in bits
DEAD, 1, cycles with all drivers off before a source is enabled (>=1)
DRIVE, 2, cycles a source is enabled; the bus is sampled on the last one (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
req  in  N  per-source transfer request, level, held until ack
ack  out  N  one-cycle pulse to the granted source when its transfer completes
en  out  N  TINV EN per source
nen  out  N  TINV nEN per source
bus_in  in  W  bus as seen at the receiver (inverted data from the active TINV)
rdata  out  W  captured word, true polarity
rvalid  out  1  one-cycle strobe, rdata valid
src  out  clog2(N)  index of the source that produced rdata
busy  out  1  high in any state other than IDLE

Behaviour:
- One clock; reset is asynchronous and active-high. clk and rst as named above.
- Reset values: en=0, nen=all 1, ack=0, rvalid=0, rdata=0, src=0, busy=0, state IDLE, round-robin pointer ptr=0.
- Reset asserted mid-transfer forces all drivers off immediately (asynchronously), without waiting for a clock edge.
- Invariant at all times: nen[i] == ~en[i] for every i; en is zero-or-one-hot.
- All outputs are registered; en/nen are decoded from the registered state and grant.
- FSM states: IDLE, TURN, DRIVE, DONE.
- IDLE:
  - If req != 0, grant g = first set req bit searching ptr, ptr+1, ... (mod N).
  - Register g; load counter with DEAD; go to TURN.
- TURN:
  - All en=0.
  - Counter decrements each cycle. After DEAD cycles, load counter with DRIVE and go to DRIVE.
- DRIVE:
  - en[g]=1, nen[g]=0; all other sources off.
  - On the last DRIVE cycle, capture rdata <= ~bus_in and src <= g.
  - Go to DONE.
- DONE:
  - All en=0.
  - rvalid=1 and ack[g]=1 for exactly this cycle.
  - ptr <= (g+1) mod N; go to IDLE.
- Latency: req sampled in IDLE at cycle 0.
  - TURN occupies cycles 1..DEAD.
  - DRIVE occupies cycles DEAD+1..DEAD+DRIVE.
  - rvalid/ack occur at cycle DEAD+DRIVE+1.
  - Back-to-back transfers start every DEAD+DRIVE+2 cycles.
- Handshake:
  - req must stay high until ack.
  - req dropped after grant: the transfer still completes and ack is still pulsed.
  - req dropped before grant: the source is never granted.
  - req is ignored outside IDLE.
- Simultaneous requests: strict round-robin; no source is granted twice while another is pending.
- A source's drive window is always separated from the previous one by at least DEAD+2 cycles with all drivers off (DONE, IDLE, TURN).
- Wrap-around: ptr advances from N-1 to 0.
- N not a power of two: grant indices >= N are never produced.

Test Plan:
- Reset then req=0001, N=4 W=8 DEAD=1 DRIVE=2, bus_in=8'h5A -> en=0001/nen=1110 in cycles 2..3; rvalid, ack=0001, rdata=8'hA5, src=0 at cycle 4; all drivers off otherwise.
- req=1111 held, each source re-raises req after its ack -> grants in order 0,1,2,3,0; new transfers start every 5 cycles; en never has more than one bit set; en and nen are never both 1 or both 0 on any bit.
- req=0100 dropped one cycle after grant -> transfer completes and ack=0100 is pulsed; a second req=0100 pulsed for one cycle while busy -> ignored.
- rst asserted asynchronously mid-DRIVE between clock edges -> en=0 and nen=1111 immediately; rvalid=0 and ack=0; after release, state IDLE and ptr=0.
- DEAD=3, DRIVE=1, bus_in changes every cycle -> rdata equals ~bus_in from the single DRIVE cycle; rvalid at cycle 5.
- N=3, req=100 then 001 -> grant 2, then grant 0 (ptr wraps); no en bit at index 3 ever set.
